rv_int_exec: RTL and testbench
==============================

# rv_int_exec

Parametrised RV32I/RV64I integer execute unit with its own general-purpose register file. Accepts one R-type (opcode 0110011) or I-type ALU (opcode 0010011) instruction at a time over a valid/ready handshake, executes it in a small FSM, writes the result to the register file and reports it on a one-cycle writeback strobe. It is the next-generation ALU stage of the processor: fetch/decode feeds it, and the load/store and branch units are separate blocks.

## Interface
- XLEN, 32, datapath and register width; legal values 32 and 64.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- instr_valid  input  1  instr holds an instruction to execute.
- instr_ready  output  1  unit can accept; equals (state == IDLE).
- instr  input  32  instruction word; sampled only on handshake.
- wb_valid  output  1  one-cycle pulse: instruction retired legally.
- wb_rd  output  5  destination register of the retired instruction.
- wb_data  output  XLEN  value written; 0 when wb_rd = 0.
- illegal  output  1  one-cycle pulse: instruction unsupported, no write.
- dbg_raddr  input  5  debug read address.
- dbg_rdata  output  XLEN  combinational GPR[dbg_raddr]; 0 when dbg_raddr = 0.

## Operation
- Register file: 32 x XLEN. x0 reads 0 and is never written.
- FSM states: IDLE, EXEC, SHIFT (only with the macro), RETIRE.
- IDLE: handshake (instr_valid & instr_ready) latches instr into IR and moves to EXEC; otherwise stays.
- EXEC: decode funct3/funct7 and operands; result is captured. Legal shift with nonzero shamt under the macro goes to SHIFT; everything else goes to RETIRE.
- RETIRE: GPR[rd] is written (unless rd = 0); wb_valid or illegal pulses; returns to IDLE.
- R-type: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND. funct7 = 0000000, except SUB/SRA which use 0100000.
- I-type: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
- imm = sign-extended IR[31:20] to XLEN.
- Shift amount: XLEN=32 uses rs2[4:0] or IR[24:20], with the I-type shift funct7 (IR[31:25]) checked. XLEN=64 uses rs2[5:0] or IR[25:20], with IR[31:26] checked (000000, or 010000 for SRAI).
- SLT/SLTI compare signed. SLTU/SLTIU compare unsigned; SLTIU compares against the sign-extended imm treated as unsigned. Result is zero-extended 0 or 1.
- Add/sub wrap modulo 2^XLEN; no overflow flag.
- Illegal: any other opcode, or a funct3/funct7 combination not listed. Illegal instructions cause no GPR write; illegal pulses, wb_valid stays 0, and wb_rd/wb_data hold their previous values.
- rd = 0 on a legal instruction: wb_valid pulses, wb_rd = 0, wb_data = 0.

## Timing
- Reset values:
  - state IDLE, instr_ready 1.
  - wb_valid 0, illegal 0, wb_rd 0, wb_data 0.
  - All GPRs 0.
- Reset asserted mid-instruction: instruction abandoned, no GPR write, no pulse.
- Handshake at edge E0 → EXEC → RETIRE → wb_valid/illegal high for exactly the cycle after edge E2.
- GPR update is visible on dbg_rdata in that same cycle.
- instr_ready is 0 from E0 until state returns to IDLE, i.e. it rises in the same cycle as the wb_valid pulse. Peak throughput is one instruction per 3 cycles.
- instr is ignored while instr_ready = 0.
- Operands are read from the GPR in EXEC. Back-to-back dependent instructions therefore see the prior result; no forwarding is needed.

## Configuration
- ITER_SHIFT_EN defined:
  - SLL/SRL/SRA and their I-forms shift one bit per cycle in SHIFT.
  - A shift with shamt n retires n cycles later than a non-shift, i.e. wb_valid falls in the cycle after edge E2+n.
  - shamt = 0 skips SHIFT.
  - SRA replicates the sign bit on each step.
- ITER_SHIFT_EN undefined: single-cycle barrel shifter in EXEC; SHIFT state absent; all instructions have 3-cycle latency.

## Test plan
- Reset, then ADDI x1,x0,-5 → wb_valid, wb_rd=1, wb_data=0xFFFFFFFB (XLEN=32); dbg_raddr=1 reads the same value.
- With x1=0xFFFFFFFB and x2=3: SLT x3,x1,x2 → 1; SLTU x4,x1,x2 → 0; SUB x5,x2,x1 → 8.
- SRA x6,x1,x2 → 0xFFFFFFFF; SRL x7,x1,x2 → 0x1FFFFFFF. With ITER_SHIFT_EN, wb_valid arrives exactly 3 cycles later than for ADD.
- ADDI x0,x0,7 → wb_valid with wb_rd=0, wb_data=0, and x0 still reads 0. Then instr=0x00000000 → illegal pulse, no wb_valid, all GPRs unchanged.
- Hold instr_valid high continuously with 4 ADDIs → exactly 4 handshakes, with instr_ready low for the 2 cycles after each. Asserting rst_n=0 during EXEC → no write, and wb_valid stays 0.
- XLEN=64: SLLI x8,x9,40 with x9=1 → 0x0000010000000000. SLLI with IR[31:26]=000001 → illegal.

Source files
------------

// File: rtl/rv_int_exec.sv
// rv_int_exec: RV32I/RV64I integer execute unit with a private 32-entry GPR file.
// Takes one ALU instruction (R-type or I-type) at a time and runs it through
// IDLE -> EXEC -> RETIRE. Retirement is signalled by a one-cycle pulse on
// wb_valid, or on illegal for an unsupported encoding.
// Build option ITER_SHIFT_EN: shifts go through an extra SHIFT state that moves
// one bit per cycle. Without it, shifts use a single-cycle barrel shifter in EXEC.
module rv_int_exec #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            illegal,
  input  logic [4:0]      dbg_raddr,
  output logic [XLEN-1:0] dbg_rdata
);

  // Width of the shift amount field: 5 bits for RV32, 6 bits for RV64.
  localparam int SHW = (XLEN == 64) ? 6 : 5;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
`ifdef ITER_SHIFT_EN
    SHIFT,
`endif
    RETIRE
  } state_t;

  state_t          r_state, w_state_next;
  logic [31:0]     r_ir;
  logic [XLEN-1:0] r_result;
  logic            r_legal;
  logic [XLEN-1:0] r_gpr [0:31];
  logic            r_wb_valid, r_illegal;
  logic [4:0]      r_wb_rd;
  logic [XLEN-1:0] r_wb_data;
`ifdef ITER_SHIFT_EN
  logic [SHW-1:0]  r_cnt;
  logic [XLEN-1:0] w_step;
`endif

  // Field decode of the latched instruction.
  logic [6:0]             w_opcode, w_f7;
  logic [4:0]             w_rd, w_rs1, w_rs2;
  logic [2:0]             w_f3;
  logic                   w_is_r, w_is_i, w_sub, w_is_shift, w_hi_ok, w_legal;
  logic [XLEN-1:0]        w_imm, w_rs1_val, w_rs2_val, w_op_b, w_alu;
  logic [SHW-1:0]         w_shamt;
  logic signed [XLEN-1:0] w_sra;
  logic                   w_lt_s, w_lt_u, w_gpr_we;

  assign w_opcode  = r_ir[6:0];
  assign w_rd      = r_ir[11:7];
  assign w_f3      = r_ir[14:12];
  assign w_rs1     = r_ir[19:15];
  assign w_rs2     = r_ir[24:20];
  assign w_f7      = r_ir[31:25];
  assign w_is_r    = (w_opcode == 7'b0110011);
  assign w_is_i    = (w_opcode == 7'b0010011);
  assign w_imm     = {{(XLEN-12){r_ir[31]}}, r_ir[31:20]};
  assign w_rs1_val = (w_rs1 == 5'd0) ? '0 : r_gpr[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? '0 : r_gpr[w_rs2];
  assign w_op_b    = w_is_r ? w_rs2_val : w_imm;
  assign w_shamt   = w_is_r ? w_rs2_val[SHW-1:0] : r_ir[20 +: SHW];
  assign w_sub     = w_is_r & r_ir[30];
  assign w_is_shift = (w_f3 == 3'b001) || (w_f3 == 3'b101);
  // Upper immediate bits above shamt must be zero, except bit 30 (SRAI selector).
  assign w_hi_ok   = ~r_ir[31] && (r_ir[29:20+SHW] == '0);
  assign w_sra     = $signed(w_rs1_val) >>> w_shamt;
  assign w_lt_s    = $signed(w_rs1_val) < $signed(w_op_b);
  assign w_lt_u    = w_rs1_val < w_op_b;
  assign w_gpr_we  = (r_state == RETIRE) && r_legal && (w_rd != 5'd0);

  // Legality of the funct3/funct7 combination for the two supported opcodes.
  always_comb begin
    w_legal = 1'b0;
    if (w_is_r) begin
      w_legal = (w_f7 == 7'b0000000) ||
                ((w_f7 == 7'b0100000) && ((w_f3 == 3'b000) || (w_f3 == 3'b101)));
    end else if (w_is_i) begin
      case (w_f3)
        3'b001:  w_legal = w_hi_ok & ~r_ir[30];
        3'b101:  w_legal = w_hi_ok;
        default: w_legal = 1'b1;
      endcase
    end
  end

  // ALU result; in iterative mode shifts start from rs1 and are finished in SHIFT.
  always_comb begin
    w_alu = '0;
    case (w_f3)
      3'b000: w_alu = w_sub ? (w_rs1_val - w_op_b) : (w_rs1_val + w_op_b);
`ifdef ITER_SHIFT_EN
      3'b001: w_alu = w_rs1_val;
      3'b101: w_alu = w_rs1_val;
`else
      3'b001: w_alu = w_rs1_val << w_shamt;
      3'b101: w_alu = r_ir[30] ? w_sra : (w_rs1_val >> w_shamt);
`endif
      3'b010: w_alu = {{(XLEN-1){1'b0}}, w_lt_s};
      3'b011: w_alu = {{(XLEN-1){1'b0}}, w_lt_u};
      3'b100: w_alu = w_rs1_val ^ w_op_b;
      3'b110: w_alu = w_rs1_val | w_op_b;
      3'b111: w_alu = w_rs1_val & w_op_b;
      default: w_alu = '0;
    endcase
  end

`ifdef ITER_SHIFT_EN
  // One-bit step of the iterative shifter; bit 30 selects arithmetic right shift.
  always_comb begin
    w_step = r_result;
    if (w_f3 == 3'b001) w_step = {r_result[XLEN-2:0], 1'b0};
    else                w_step = {r_ir[30] & r_result[XLEN-1], r_result[XLEN-1:1]};
  end
`endif

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (instr_valid) w_state_next = EXEC;
`ifdef ITER_SHIFT_EN
      EXEC:    w_state_next = (w_legal && w_is_shift && (w_shamt != '0)) ? SHIFT : RETIRE;
      SHIFT:   if (r_cnt == SHW'(1)) w_state_next = RETIRE;
`else
      EXEC:    w_state_next = RETIRE;
`endif
      RETIRE:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Instruction latch and execution result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir     <= '0;
      r_result <= '0;
      r_legal  <= 1'b0;
`ifdef ITER_SHIFT_EN
      r_cnt    <= '0;
`endif
    end else begin
      if (r_state == IDLE && instr_valid) r_ir <= instr;
      if (r_state == EXEC) begin
        r_result <= w_alu;
        r_legal  <= w_legal;
`ifdef ITER_SHIFT_EN
        r_cnt    <= w_shamt;
`endif
      end
`ifdef ITER_SHIFT_EN
      if (r_state == SHIFT) begin
        r_result <= w_step;
        r_cnt    <= r_cnt - SHW'(1);
      end
`endif
    end
  end

  // Register file; x0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_gpr[i] <= '0;
    end else if (w_gpr_we) begin
      r_gpr[w_rd] <= r_result;
    end
  end

  // Retirement pulses; wb_rd/wb_data hold across illegal instructions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid <= 1'b0;
      r_illegal  <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      r_illegal  <= 1'b0;
      if (r_state == RETIRE) begin
        if (r_legal) begin
          r_wb_valid <= 1'b1;
          r_wb_rd    <= w_rd;
          r_wb_data  <= (w_rd == 5'd0) ? '0 : r_result;
        end else begin
          r_illegal  <= 1'b1;
        end
      end
    end
  end

  assign instr_ready = (r_state == IDLE);
  assign wb_valid    = r_wb_valid;
  assign illegal     = r_illegal;
  assign wb_rd       = r_wb_rd;
  assign wb_data     = r_wb_data;
  assign dbg_rdata   = (dbg_raddr == 5'd0) ? '0 : r_gpr[dbg_raddr];

endmodule

// File: tb/tb_rv_int_exec.sv
// tb_rv_int_exec: scoreboard bench for rv_int_exec. Stimulus predicts each
// instruction's outcome with an architectural model and queues it; a monitor
// pops and compares on every wb_valid/illegal pulse.
module tb_rv_int_exec;
  parameter int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            instr_valid = 1'b0;
  logic            instr_ready;
  logic [31:0]     instr = '0;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            illegal;
  logic [4:0]      dbg_raddr = '0;
  logic [XLEN-1:0] dbg_rdata;

  rv_int_exec #(.XLEN(XLEN)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .illegal(illegal), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit              ill;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] dbg;
    int              lat;
  } exp_t;

  exp_t            sb[$];
  logic [XLEN-1:0] m_gpr [32];
  logic [4:0]      m_wb_rd;
  logic [XLEN-1:0] m_wb_data;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_hs = 0;
  int hs_count = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'h13};
  endfunction

  // Architectural model: decide legality and result from the ISA rules, update
  // the model register file and queue the expected retirement.
  task automatic predict(input logic [31:0] ins);
    bit                     isr = (ins[6:0] == 7'h33);
    bit                     isi = (ins[6:0] == 7'h13);
    logic [2:0]             f3 = ins[14:12];
    logic [6:0]             f7 = ins[31:25];
    logic [4:0]             rd = ins[11:7];
    logic [11:0]            hi = ins[31:20];
    logic signed [XLEN-1:0] imm = $signed(ins[31:20]);
    logic [XLEN-1:0]        a = m_gpr[ins[19:15]];
    logic [XLEN-1:0]        b;
    logic [XLEN-1:0]        res = '0;
    logic [XLEN-1:0]        ones = '1;
    int                     sh;
    bit                     ok = 0;
    exp_t                   e;
    b  = isr ? m_gpr[ins[24:20]] : imm;
    sh = int'(b % XLEN);
    if (isr)      ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
    else if (isi) begin
      if (f3 == 3'd1)      ok = ((hi >> $clog2(XLEN)) == 12'd0);
      else if (f3 == 3'd5) ok = (((hi & ~12'h400) >> $clog2(XLEN)) == 12'd0);
      else                 ok = 1;
    end
    case (f3)
      3'd0: res = (isr && f7 == 7'h20) ? a - b : a + b;
      3'd1: res = a << sh;
      3'd2: res[0] = ($signed(a) < $signed(b));
      3'd3: res[0] = (a < b);
      3'd4: res = a ^ b;
      3'd5: begin
        res = a >> sh;
        if (ins[30] && a[XLEN-1]) res = res | ~(ones >> sh);
      end
      3'd6: res = a | b;
      default: res = a & b;
    endcase
    e.lat = 2;
    if (ok) begin
      if (rd != 5'd0) m_gpr[rd] = res;
      m_wb_rd   = rd;
      m_wb_data = (rd == 5'd0) ? '0 : res;
`ifdef ITER_SHIFT_EN
      if (f3 == 3'd1 || f3 == 3'd5) e.lat = 2 + sh;
`endif
    end
    e.ill  = !ok;
    e.rd   = m_wb_rd;
    e.data = m_wb_data;
    e.dbg  = m_gpr[rd];
    sb.push_back(e);
  endtask

  // Cycle and handshake bookkeeping.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && instr_valid && instr_ready) begin
      hs_count <= hs_count + 1;
      last_hs  <= cyc + 1;
    end
  end

  // Monitor: compare every retirement pulse against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && (wb_valid || illegal)) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: wb_valid=%0b illegal=%0b with nothing outstanding", wb_valid, illegal);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_kind", {wb_valid, illegal}, e.ill ? 2'b01 : 2'b10);
        chk("wb_rd", wb_rd, e.rd);
        chk("wb_data", wb_data, e.data);
        chk("dbg_rdata", dbg_rdata, e.dbg);
        chk("latency", cyc - last_hs, e.lat);
      end
    end
  end

  task automatic issue(input logic [31:0] ins, input bit keep);
    int g = 0;
    while (!instr_ready && g < 300) begin @(negedge clk); g++; end
    chk("ready_before_issue", instr_ready, 1'b1);
    #1;
    instr = ins;
    instr_valid = 1'b1;
    dbg_raddr = ins[11:7];
    predict(ins);
    @(negedge clk);
    chk("ready_low_1", instr_ready, 1'b0);
    #1;
    if (!keep) instr_valid = 1'b0;
    @(negedge clk);
    chk("ready_low_2", instr_ready, 1'b0);
  endtask

  task automatic wait_drain();
    int g = 0;
    while (sb.size() != 0 && g < 500) begin @(negedge clk); g++; end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d retirements outstanding, required 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic dbg_chk(input string name, input logic [4:0] addr, input logic [XLEN-1:0] exp);
    #1;
    dbg_raddr = addr;
    #1;
    chk(name, dbg_rdata, exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [XLEN-1:0] m5;
    logic [11:0]     top_sh;
    int              h0;
    m5 = -5;
    top_sh = 12'(XLEN - 1);
    for (int i = 0; i < 32; i++) m_gpr[i] = '0;
    m_wb_rd = '0;
    m_wb_data = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", instr_ready, 1'b1);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_wb_rd", wb_rd, 5'd0);
    chk("rst_wb_data", wb_data, '0);
    for (int r = 1; r < 32; r += 5) dbg_chk("rst_gpr", 5'(r), '0);
    @(negedge clk);

    // Directed sequence.
    issue(enc_i(12'hFFB, 5'd0, 3'd0, 5'd1), 0);    // ADDI x1,x0,-5
    issue(enc_i(12'd3, 5'd0, 3'd0, 5'd2), 0);      // ADDI x2,x0,3
    issue(enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd3), 0); // SLT x3,x1,x2
    issue(enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd4), 0); // SLTU x4,x1,x2
    issue(enc_r(7'h20, 5'd1, 5'd2, 3'd0, 5'd5), 0); // SUB x5,x2,x1
    issue(enc_r(7'h20, 5'd2, 5'd1, 3'd5, 5'd6), 0); // SRA x6,x1,x2
    issue(enc_r(7'h00, 5'd2, 5'd1, 3'd5, 5'd7), 0); // SRL x7,x1,x2
    issue(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd8), 0); // ADD x8,x1,x2
    issue(enc_i(12'd7, 5'd0, 3'd0, 5'd0), 0);      // ADDI x0,x0,7
    issue(32'h0000_0000, 0);                       // illegal opcode
    issue(enc_r(7'h20, 5'd2, 5'd1, 3'd1, 5'd9), 0); // SLL with funct7 0100000
    issue(enc_i(12'h402, 5'd1, 3'd1, 5'd9), 0);    // SLLI with bit 30 set
    issue(enc_i(12'hC01, 5'd1, 3'd5, 5'd9), 0);    // shift-right with bit 31 set
    issue(enc_i(12'h404, 5'd1, 3'd5, 5'd10), 0);   // SRAI x10,x1,4
    issue(enc_i(top_sh, 5'd2, 3'd1, 5'd11), 0);    // SLLI x11,x2,XLEN-1
    issue(enc_i(12'hFFF, 5'd2, 3'd3, 5'd12), 0);   // SLTIU x12,x2,-1
    issue(enc_i(12'hFFF, 5'd2, 3'd2, 5'd13), 0);   // SLTI x13,x2,-1
    wait_drain();
    dbg_chk("x1_addi_neg5", 5'd1, m5);
    dbg_chk("x3_slt", 5'd3, XLEN'(1));
    dbg_chk("x4_sltu", 5'd4, '0);
    dbg_chk("x5_sub", 5'd5, XLEN'(8));
    dbg_chk("x6_sra", 5'd6, '1);
    dbg_chk("x7_srl", 5'd7, m5 >> 3);
    dbg_chk("x9_untouched", 5'd9, '0);
    dbg_chk("x12_sltiu", 5'd12, XLEN'(1));
    dbg_chk("x13_slti", 5'd13, '0);
    dbg_chk("x0_zero", 5'd0, '0);

    // instr_valid held high across four back-to-back ADDIs.
    h0 = hs_count;
    for (int k = 0; k < 4; k++)
      issue(enc_i(12'(k * 17 + 1), 5'(14 + k), 3'd0, 5'(15 + k)), (k != 3));
    wait_drain();
    chk("hs_count_4", hs_count - h0, 4);

    // Randomised instruction stream.
    for (int n = 0; n < 200; n++) begin
      logic [31:0] ins;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [11:0] imm;
      int          kind;
      int          sh;
      kind = $urandom_range(0, 9);
      f3 = 3'($urandom_range(0, 7));
      sh = $urandom_range(0, XLEN - 1);
      if (kind == 0) begin
        ins = $urandom;
      end else if (kind <= 4) begin
        f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        if ($urandom_range(0, 9) == 0) f7 = 7'($urandom);
        ins = enc_r(f7, 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), f3,
                    5'($urandom_range(0, 15)));
      end else begin
        imm = 12'($urandom);
        if (f3 == 3'd1) imm = 12'(sh);
        if (f3 == 3'd5) imm = 12'(sh) | (($urandom_range(0, 1) == 1) ? 12'h400 : 12'h000);
        if ($urandom_range(0, 9) == 0) imm = imm ^ (12'h800 >> $urandom_range(0, 5));
        ins = enc_i(imm, 5'($urandom_range(0, 15)), f3, 5'($urandom_range(0, 15)));
      end
      issue(ins, 0);
    end
    wait_drain();

    // Reset asserted while the instruction is in EXEC.
    #1;
    instr = enc_i(12'd100, 5'd0, 3'd0, 5'd9);
    instr_valid = 1'b1;
    dbg_raddr = 5'd9;
    @(negedge clk);
    #1;
    instr_valid = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) m_gpr[i] = '0;
    m_wb_rd = '0;
    m_wb_data = '0;
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("no_wb_after_rst", wb_valid, 1'b0);
    end
    chk("rst_mid_wb_rd", wb_rd, 5'd0);
    chk("rst_mid_wb_data", wb_data, '0);
    dbg_chk("rst_mid_x9", 5'd9, '0);
    dbg_chk("rst_mid_x1", 5'd1, '0);
    @(negedge clk);
    issue(enc_i(12'd100, 5'd0, 3'd0, 5'd9), 0);
    issue(enc_i(12'h001, 5'd9, 3'd1, 5'd10), 0);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
